// File: rtl/mem_arbiter.sv
// Two-master single-port RAM arbiter with a one-deep command register.
// Optional ARB_ROUND_ROBIN_EN: round-robin on contention (default fixed m0 priority).
module mem_arbiter #(
  parameter int          ADDRESS_WIDTH = 32,
  parameter logic [31:0] RAM_TOP       = 32'h00001FFF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     m0_req,
  input  logic                     m0_we,
  input  logic [ADDRESS_WIDTH-1:0] m0_addr,
  input  logic [31:0]              m0_wdata,
  output logic                     m0_gnt,
  output logic                     m0_rvalid,
  output logic [31:0]              m0_rdata,
  output logic                     m0_err,
  input  logic                     m1_req,
  input  logic                     m1_we,
  input  logic [ADDRESS_WIDTH-1:0] m1_addr,
  input  logic [31:0]              m1_wdata,
  output logic                     m1_gnt,
  output logic                     m1_rvalid,
  output logic [31:0]              m1_rdata,
  output logic                     m1_err,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [31:0]              ram_wdata,
  input  logic [31:0]              ram_rdata
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_WORD =
    ADDRESS_WIDTH'(RAM_TOP - 32'd3);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t state_q;
  state_t state_d;

  logic                     pick_m1;
  logic                     any_gnt;
  logic                     sel_we;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [31:0]              sel_wdata;
  logic                     sel_bad;

  logic                     cmd_m1;
  logic                     cmd_we;
  logic                     cmd_err;
  logic [ADDRESS_WIDTH-1:0] cmd_addr;
  logic [31:0]              cmd_wdata;
  logic [31:0]              read_data;

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant = 1 means m1 was granted last, so m0 wins next contention
  logic last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (any_gnt) begin
      last_grant <= pick_m1;
    end
  end

  assign pick_m1 = m1_req & (~m0_req | ~last_grant);
`else
  assign pick_m1 = m1_req & ~m0_req;
`endif

  assign m1_gnt  = rst_n & pick_m1;
  assign m0_gnt  = rst_n & m0_req & ~pick_m1;
  assign any_gnt = m0_gnt | m1_gnt;

  assign sel_we    = pick_m1 ? m1_we    : m0_we;
  assign sel_addr  = pick_m1 ? m1_addr  : m0_addr;
  assign sel_wdata = pick_m1 ? m1_wdata : m0_wdata;
  assign sel_bad   = (sel_addr[1:0] != 2'b00) ||
                     (sel_addr > LAST_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_m1    <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_err   <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (any_gnt) begin
      cmd_m1    <= pick_m1;
      cmd_we    <= sel_we;
      cmd_err   <= sel_bad;
      cmd_addr  <= sel_addr;
      cmd_wdata <= sel_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign read_data = (cmd_we | cmd_err) ? 32'd0 : ram_rdata;

  always_comb begin
    state_d   = IDLE;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    m0_err    = 1'b0;
    m1_err    = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = any_gnt ? BUSY : IDLE;
      end
      BUSY: begin
        state_d   = any_gnt ? BUSY : IDLE;
        ram_we    = cmd_we & ~cmd_err;
        ram_addr  = cmd_addr;
        ram_wdata = cmd_wdata;
        m0_rvalid = ~cmd_m1;
        m1_rvalid = cmd_m1;
        m0_err    = ~cmd_m1 & cmd_err;
        m1_err    = cmd_m1 & cmd_err;
        m0_rdata  = cmd_m1 ? 32'd0 : read_data;
        m1_rdata  = cmd_m1 ? read_data : 32'd0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural RAM.
// Contention expectations follow ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  logic [31:0] mem [0:2047];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  assign ram_rdata = mem[ram_addr[12:2]];

  always @(posedge clk)
    if (ram_we) mem[ram_addr[12:2]] <= ram_wdata;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    cyc();
    m0_req = 1'b1; m0_addr = 32'h100;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b0) begin
      errors++; $display("FAIL rst_gnt: got %b want 0", m0_gnt);
    end
    checks++;
    if ({ram_we, ram_addr, ram_wdata} !== 65'd0) begin
      errors++;
      $display("FAIL rst_ram: we=%b addr=%h wd=%h want 0", ram_we, ram_addr, ram_wdata);
    end
    checks++;
    if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0) begin
      errors++;
      $display("FAIL rst_rvalid: got %b want 0000", {m0_rvalid, m1_rvalid, m0_err, m1_err});
    end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1) begin
      errors++; $display("FAIL first_gnt: got %b want 1", m0_gnt);
    end
    cyc();
    idle();
    @(negedge clk);
    checks++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL first_read: rv=%b data=%h want 1 deadbeef", m0_rvalid, m0_rdata);
    end
    cyc();
  endtask

  task automatic test_single_read();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h100;
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      errors++; $display("FAIL rd_gnt: got %b want 01", {m0_gnt, m1_gnt});
    end
    cyc();
    idle();
    @(negedge clk);
    checks++;
    if ({m1_rvalid, m1_err, m0_rvalid} !== 3'b100 || m1_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_resp: rv/err/rv0=%b data=%h want 100 deadbeef",
               {m1_rvalid, m1_err, m0_rvalid}, m1_rdata);
    end
    checks++;
    if (ram_addr !== 32'h100) begin
      errors++; $display("FAIL rd_addr: got %h want 100", ram_addr);
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({m1_rvalid, ram_addr} !== 33'd0) begin
      errors++; $display("FAIL rd_idle: rv=%b addr=%h want 0", m1_rvalid, ram_addr);
    end
  endtask

  task automatic test_write_read();
    cyc();
    m0_req = 1'b1; m0_we = 1'b1;
    m0_addr = 32'h1FFC; m0_wdata = 32'h12345678;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1 || ram_we !== 1'b0) begin
      errors++; $display("FAIL wr_gnt: gnt=%b we=%b want 1 0", m0_gnt, ram_we);
    end
    cyc();
    m0_we = 1'b0; m0_wdata = '0;
    @(negedge clk);
    checks++;
    if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 32'h1FFC, 32'h12345678}) begin
      errors++;
      $display("FAIL wr_ram: we=%b addr=%h wd=%h want 1 1ffc 12345678",
               ram_we, ram_addr, ram_wdata);
    end
    checks++;
    if ({m0_rvalid, m0_err, m0_gnt} !== 3'b101 || m0_rdata !== 32'd0) begin
      errors++;
      $display("FAIL wr_resp: rv/err/gnt=%b data=%h want 101 0",
               {m0_rvalid, m0_err, m0_gnt}, m0_rdata);
    end
    cyc();
    idle();
    @(negedge clk);
    checks++;
    if ({ram_we, m0_rvalid, m0_err} !== 3'b010 || m0_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL raw_read: we/rv/err=%b data=%h want 010 12345678",
               {ram_we, m0_rvalid, m0_err}, m0_rdata);
    end
    cyc();
  endtask

  task automatic test_contention();
    logic [3:0] exp_m0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_m0 = 4'b0101;
`else
    exp_m0 = 4'b1111;
`endif
    do_reset();
    m0_req = 1'b1; m0_addr = 32'h0;
    m1_req = 1'b1; m1_addr = 32'h4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt} !== {exp_m0[i], ~exp_m0[i]}) begin
        errors++;
        $display("FAIL contend[%0d]: m0/m1 gnt=%b want %b",
                 i, {m0_gnt, m1_gnt}, {exp_m0[i], ~exp_m0[i]});
      end
      cyc();
    end
    idle();
    cyc();
  endtask

  task automatic test_errors();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h102;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1) begin
      errors++; $display("FAIL err_gnt: got %b want 1", m0_gnt);
    end
    cyc();
    idle();
    m1_req = 1'b1; m1_we = 1'b1;
    m1_addr = 32'h1FFD; m1_wdata = 32'h55555555;
    @(negedge clk);
    checks++;
    if ({m0_rvalid, m0_err, ram_we, m1_gnt} !== 4'b1101 || m0_rdata !== 32'd0) begin
      errors++;
      $display("FAIL err_misalign: rv/err/we/gnt1=%b data=%h want 1101 0",
               {m0_rvalid, m0_err, ram_we, m1_gnt}, m0_rdata);
    end
    cyc();
    idle();
    m0_req = 1'b1; m0_addr = 32'h2000;
    @(negedge clk);
    checks++;
    if ({m1_rvalid, m1_err, ram_we} !== 3'b110 || m1_rdata !== 32'd0) begin
      errors++;
      $display("FAIL err_wr: rv/err/we=%b data=%h want 110 0",
               {m1_rvalid, m1_err, ram_we}, m1_rdata);
    end
    cyc();
    idle();
    @(negedge clk);
    checks++;
    if ({m0_rvalid, m0_err} !== 2'b11 || m0_rdata !== 32'd0) begin
      errors++;
      $display("FAIL err_range: rv/err=%b data=%h want 11 0", {m0_rvalid, m0_err}, m0_rdata);
    end
    checks++;
    if (mem[11'h7FF] !== 32'h12345678) begin
      errors++; $display("FAIL err_nowrite: got %h want 12345678", mem[11'h7FF]);
    end
    cyc();
  endtask

  task automatic test_reset_midop();
    m0_req = 1'b1; m0_we = 1'b1;
    m0_addr = 32'h200; m0_wdata = 32'hCAFEF00D;
    cyc();
    idle();
    checks++;
    if (ram_we !== 1'b1) begin
      errors++; $display("FAIL mid_we_on: got %b want 1", ram_we);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ram_we, m0_rvalid, ram_addr} !== 34'd0) begin
      errors++;
      $display("FAIL mid_drop: we=%b rv=%b addr=%h want 0", ram_we, m0_rvalid, ram_addr);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({m0_rvalid, m1_rvalid, ram_we} !== 3'b000) begin
      errors++;
      $display("FAIL mid_after: rv0/rv1/we=%b want 000", {m0_rvalid, m1_rvalid, ram_we});
    end
    checks++;
    if (mem[11'h80] !== 32'h11111111) begin
      errors++; $display("FAIL mid_mem: got %h want 11111111", mem[11'h80]);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'(4 * k);
      @(negedge clk);
      checks++;
      if (m0_gnt !== 1'b1) begin
        errors++; $display("FAIL b2b_gnt[%0d]: got %b want 1", k, m0_gnt);
      end
      if (k > 0) begin
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hA000_0000 + 32'(k - 1)) begin
          errors++;
          $display("FAIL b2b_data[%0d]: rv=%b data=%h want 1 %h",
                   k, m0_rvalid, m0_rdata, 32'hA000_0000 + 32'(k - 1));
        end
      end
      cyc();
    end
    idle();
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hA000_0007) begin
      errors++; $display("FAIL b2b_last: rv=%b data=%h want 1 a0000007", m0_rvalid, m0_rdata);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b0) begin
      errors++; $display("FAIL b2b_end: rv=%b want 0", m0_rvalid);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    for (int i = 0; i < 8; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[11'h40] = 32'hDEADBEEF;
    mem[11'h80] = 32'h11111111;
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_errors();
    test_reset_midop();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
